button_debouncer: RTL
=====================

// Module: button_debouncer
// PURPOSE
//  Upstream conditioning stage for timercontroller. Takes the raw, asynchronous,
//  bouncy push-button and drives timercontroller's b input with a clean,
//  synchronous, glitch-free level. Also emits one-cycle rise/fall strobes.
//  Rejects any input excursion shorter than STABLE_CYCLES clocks.
// PARAMETERS
//  SYNC_STAGES    2  synchronizer flop depth; legal range >= 2
//  STABLE_CYCLES  4  consecutive synchronized cycles needed to accept a new level; legal range >= 2
//  CNT_W          3  stability counter width; must satisfy 2**CNT_W > STABLE_CYCLES
// PORTS
//  clk      in   1  system clock; all logic on the rising edge
//  rst      in   1  reset; asynchronous, active-high
//  btn_raw  in   1  raw button; asynchronous to clk, may bounce
//  b        out  1  debounced level; drives timercontroller.b
//  b_rise   out  1  one-cycle strobe, high in the same cycle b goes 0->1
//  b_fall   out  1  one-cycle strobe, high in the same cycle b goes 1->0
// BEHAVIOUR
//  - Reset (async assert, sync-released by clk):
//    - all sync flops = 0, cnt = 0, state = LOW
//    - b = 0, b_rise = 0, b_fall = 0
//  - All outputs are registered; there is no combinational path from btn_raw.
//  - Synchronizer: btn_raw passes through SYNC_STAGES flops; s = last stage.
//  - FSM states: LOW, CHK_HI, HIGH, CHK_LO.
//    - LOW: b = 0.
//      s=1 -> CHK_HI with cnt=1.
//      else stay, cnt=0.
//    - CHK_HI: b = 0.
//      s=0 -> LOW, cnt=0 (glitch rejected).
//      s=1 and cnt==STABLE_CYCLES-1 -> HIGH, cnt=0, b=1, b_rise=1 for this one cycle.
//      else cnt=cnt+1.
//    - HIGH and CHK_LO: mirror of LOW and CHK_HI with polarity swapped.
//      CHK_LO accepting -> LOW, b=0, b_fall=1.
//  - Latency: btn_raw first sampled high at edge k and held ->
//    b=1 after edge k+SYNC_STAGES+STABLE_CYCLES-1 (defaults: k+5).
//    Release is symmetric.
//  - Rejection: a pulse lasting < STABLE_CYCLES synchronized cycles never changes b,
//    and never asserts a strobe.
//  - Bounce during CHK_*: any reversion restarts from cnt=0 in the original state.
//    There is no partial credit.
//  - b_rise and b_fall are never high together.
//  - Minimum spacing between any two strobes is STABLE_CYCLES cycles.
//  - cnt never exceeds STABLE_CYCLES-1 and never wraps.
//  - Reset mid-check (e.g. in CHK_HI with cnt=2):
//    - returns to LOW, b=0, no strobe.
//    - If btn_raw is still high after release, a full new qualification is required.
//  - Held input: while s equals b the FSM idles, with no counting and no strobes.
// STRUCTURE
//  - Shared include btn_defs.vh:
//    - state encoding localparams S_LOW=2'd0, S_CHK_HI=2'd1, S_HIGH=2'd2, S_CHK_LO=2'd3
//    - default parameter values
//  - Sub-module sync_chain #(STAGES):
//    - ports clk, rst, d, q
//    - reset value 0
//    - reusable for other async inputs
//  - Top level holds: FSM state register, cnt register, output registers.
// TESTING (bench instantiates button_debouncer -> timercontroller; clk period 10)
//  1. Reset held, btn_raw=1 -> b=0, b_rise=0, b_fall=0 throughout reset.
//  2. Clean press: btn_raw 0->1 before edge k, held 10 cycles ->
//     b=1 from edge k+5, b_rise=1 for exactly 1 cycle,
//     timercontroller x high for its 3-cycle window.
//  3. Glitch: btn_raw high for 3 cycles, then low -> b stays 0, no strobes.
//  4. Bounce: pattern 1,1,0,1,1,1,1 ->
//     counter restarts at the 0, b rises 4 synchronized cycles after the final 1-run starts.
//  5. Release: from b=1, btn_raw held low 6 cycles -> b=0 at edge k+5, b_fall=1 for 1 cycle.
//  6. Reset mid-check: assert rst while in CHK_HI (cnt=2), btn_raw stays 1 ->
//     b=0 immediately; after release, b=1 only after a full 5-edge qualification.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding
// and default parameter values.
package button_debouncer_pkg;

    // Default parameter values
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 3;

    // Debouncer FSM states. The encoding is fixed so the state is readable in waveforms.
    // States with a 1 in bit 1 (HIGH, CHK_LO) are the ones where the accepted level is 1.
    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_CHK_HI = 2'd1,
        S_HIGH   = 2'd2,
        S_CHK_LO = 2'd3
    } db_state_e;

endpackage

// File: rtl/button_debouncer_sync_chain.sv
// Multi-flop synchronizer for one asynchronous input bit. It resets to 0
// and can be reused for any other async input that needs the same treatment.
module sync_chain #(
    parameter int STAGES = 2            // flop depth, must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] q_q;

    // Shift the raw input through the chain. Only stage 0 can go metastable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= {q_q[STAGES-2:0], d};
    end

    assign q = q_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer. It synchronizes the raw button, then qualifies
// every level change with STABLE_CYCLES consecutive equal samples before
// it accepts the change. It drives a clean level plus one-cycle rise and
// fall strobes. Every output comes straight from a flop.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,    // >= 2
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,  // >= 2
    parameter int CNT_W         = DEF_CNT_W           // 2**CNT_W > STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic b,
    output logic b_rise,
    output logic b_fall
);

    // The last sample of a qualification run is the one taken when the count
    // has reached STABLE_CYCLES-1. The count is therefore always below STABLE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic            s;
    db_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            b_q;
    logic            rise_q;
    logic            fall_q;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (s)
    );

    // Qualification FSM. The level register and the strobe registers are
    // updated on the same edge that accepts a change. A reversion during a
    // check drops back to the settled state with no partial credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            b_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                S_LOW: begin
                    if (s) begin
                        state_q <= S_CHK_HI;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_CHK_HI: begin
                    if (!s) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                        b_q     <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!s) begin
                        state_q <= S_CHK_LO;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_CHK_LO: begin
                    if (s) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                        b_q     <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= S_LOW;
                    cnt_q   <= '0;
                    b_q     <= 1'b0;
                end
            endcase
        end
    end

    assign b      = b_q;
    assign b_rise = rise_q;
    assign b_fall = fall_q;

endmodule
